// File: rtl/hazard_pkg.sv
// Shared definitions for the D-stage hazard scoreboard.
//   FWD_*       : forward-select codes driven on fwd_rs_sel / fwd_rt_sel
//   TUSE_NONE   : Tuse value meaning "operand not read"
//   sb_entry_t  : one scoreboard slot {dst, tnew}
//   sb_match_t  : result of looking up a source register in the scoreboard
//   tnew_dec    : saturating decrement used as entries age down the pipe
package hazard_pkg;

  localparam int SB_REG_AW = 5;
  localparam int SB_TNEW_W = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [SB_TNEW_W-1:0] TUSE_NONE = '1;

  // dst == 0 marks an empty slot: $0 is never a real producer.
  typedef struct packed {
    logic [SB_REG_AW-1:0] dst;
    logic [SB_TNEW_W-1:0] tnew;
  } sb_entry_t;

  typedef struct packed {
    logic                 hit;
    logic [1:0]           stage;
    logic [SB_TNEW_W-1:0] tnew;
  } sb_match_t;

  // Floors at zero so a finished producer stays "ready" instead of wrapping.
  function automatic logic [SB_TNEW_W-1:0] tnew_dec(input logic [SB_TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - SB_TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_md_busy_counter.sv
// HI/LO multiply/divide busy counter.
//   clk, reset : core clock, async active-high reset (clears the count)
//   start      : a mult/multu/div/divu leaves D this cycle
//   is_div     : 1 = div/divu (DIV_CYCLES), 0 = mult/multu (MULT_CYCLES)
//   busy       : count is non-zero (registered state, valid the cycle after start)
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt;

  // A new start reloads even if the previous operation is still counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// D-stage hazard controller for the 5-stage MIPS core.
// Keeps a three-slot E/M/W scoreboard of {dst, remaining tnew} fed from decode,
// and derives stall and D-stage forwarding from it plus an HI/LO busy interlock.
//   clk, reset              : core clock, async active-high reset
//   D_rs, D_rt              : source indices of the D instruction
//   D_tuse_rs, D_tuse_rt    : Tuse per source (all-ones = not read)
//   D_regwrite, D_dst       : D instruction writes GPR D_dst
//   D_tnew                  : Tnew of the D instruction as it enters E
//   D_uses_md               : D instruction touches HI/LO
//   D_md_start, D_md_div    : D is mult/div (D_md_div selects div)
//   stall                   : freeze PC and F/D, bubble into E
//   fwd_rs_sel, fwd_rt_sel  : 0 regfile, 1 E, 2 M, 3 W
//   md_busy                 : HI/LO unit still working
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = SB_REG_AW,
  parameter int TNEW_W      = SB_TNEW_W,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [TNEW_W-1:0] D_tuse_rs,
  input  logic [TNEW_W-1:0] D_tuse_rt,
  input  logic              D_regwrite,
  input  logic [REG_AW-1:0] D_dst,
  input  logic [TNEW_W-1:0] D_tnew,
  input  logic              D_uses_md,
  input  logic              D_md_start,
  input  logic              D_md_div,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              md_busy
);

  sb_entry_t sb_e, sb_m, sb_w;
  sb_match_t m_rs, m_rt;
  logic      data_stall_rs, data_stall_rt, md_stall;

  // Youngest producer wins; older writers of the same register are shadowed.
  function automatic sb_match_t find_producer(input logic [REG_AW-1:0] src,
                                              input sb_entry_t e,
                                              input sb_entry_t m,
                                              input sb_entry_t w);
    sb_match_t r;
    r = '0;
    if (src != '0) begin
      if (e.dst == src)      r = '{hit: 1'b1, stage: FWD_E, tnew: e.tnew};
      else if (m.dst == src) r = '{hit: 1'b1, stage: FWD_M, tnew: m.tnew};
      else if (w.dst == src) r = '{hit: 1'b1, stage: FWD_W, tnew: w.tnew};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_e <= '0;
      sb_m <= '0;
      sb_w <= '0;
    end else begin
      sb_w <= '{dst: sb_m.dst, tnew: tnew_dec(sb_m.tnew)};
      sb_m <= '{dst: sb_e.dst, tnew: tnew_dec(sb_e.tnew)};
      if (stall) begin
        sb_e <= '0;
      end else begin
        sb_e <= '{dst: D_regwrite ? D_dst : '0, tnew: D_tnew};
      end
    end
  end

  always_comb begin
    m_rs = find_producer(D_rs, sb_e, sb_m, sb_w);
    m_rt = find_producer(D_rt, sb_e, sb_m, sb_w);
  end

  // TUSE_NONE exceeds any live tnew, but it is excluded explicitly so the
  // intent does not depend on that numeric coincidence.
  assign data_stall_rs = m_rs.hit && (D_tuse_rs != TUSE_NONE) && (m_rs.tnew > D_tuse_rs);
  assign data_stall_rt = m_rt.hit && (D_tuse_rt != TUSE_NONE) && (m_rt.tnew > D_tuse_rt);

  assign fwd_rs_sel = (m_rs.hit && m_rs.tnew == '0) ? m_rs.stage : FWD_RF;
  assign fwd_rt_sel = (m_rt.hit && m_rt.tnew == '0) ? m_rt.stage : FWD_RF;

  assign md_stall = D_uses_md && md_busy;
  assign stall    = data_stall_rs | data_stall_rt | md_stall;

  // md_busy is registered, so feeding !stall into start forms no loop.
  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (D_md_start && !stall),
    .is_div (D_md_div),
    .busy   (md_busy)
  );

endmodule
